// File: rtl/secuenciador.sv
// Instruction sequencer: fetch/decode/execute control FSM driving PC, IR, ALU, register file and data memory.
// Latency: 3 cycles per ALU/JMP/BRZ/CALL/RET instruction, 4+ cycles for LOAD; every memory wait adds one cycle.
// Backpressure: stalls in FETCH and MEMW while mem_ready is low; HALT or fault parks in STOP until rst.
//
// Ports:
//   ck, rst            clock, synchronous active-high reset
//   instr[7:0]         fetched word: [7:5] opcode, [3:0] target/operand, [4] unused
//   mem_ready          instruction/data memory word valid this cycle
//   flag_z             ALU zero flag, captured in DECODE
//   pc_in[3:0]         current PC (return-address source for CALL)
//   pc_opc[2:0]        PC command: 3'b100 update, 3'b111 hold
//   pc_x, pc_dir[3:0]  with update: 1 = load pc_dir, 0 = increment
//   ir_ld, alu_en, reg_we, mem_rd   single-cycle strobes
//   halted, fault      sticky stop indicators
//
// Optional feature: define CALL_STACK_EN to add a 4-entry return stack
// (opcode 101 CALL, opcode 111 RET). Without it both opcodes are illegal.

module secuenciador (
    input  logic       ck,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       mem_ready,
    input  logic       flag_z,
    input  logic [3:0] pc_in,
    output logic [2:0] pc_opc,
    output logic       pc_x,
    output logic [3:0] pc_dir,
    output logic       ir_ld,
    output logic       alu_en,
    output logic       reg_we,
    output logic       mem_rd,
    output logic       halted,
    output logic       fault
);

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BRZ  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_RET  = 3'b111;

    localparam logic [2:0] PC_UPD  = 3'b100;
    localparam logic [2:0] PC_HOLD = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMW   = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t     state_q, state_d;

    // Only the opcode and target fields of the word are kept; bit 4 carries no meaning.
    logic [2:0] op_q;
    logic [3:0] tgt_q;
    logic       zl_q;
    logic       halted_q;
    logic       fault_q;

    logic       ld_zl;
    logic       set_halt;
    logic       set_fault;
    logic       legal;

    logic       unused_instr4;
    assign unused_instr4 = instr[4];

`ifdef CALL_STACK_EN
    logic [3:0] stk_q [4];
    logic [2:0] sp_q;       // 0..4 entries in use
    logic       push;
    logic       pop;
    logic [1:0] top_idx;

    assign top_idx = sp_q[1:0] - 2'd1;
`else
    logic       unused_pc_in;
    assign unused_pc_in = ^pc_in;
`endif

    // Opcode legality is decided on the latched word in DECODE.
    always_comb begin
        legal = 1'b0;
        case (op_q)
            OP_ALU, OP_LOAD, OP_JMP, OP_BRZ, OP_HALT: legal = 1'b1;
`ifdef CALL_STACK_EN
            OP_CALL, OP_RET:                         legal = 1'b1;
`endif
            default:                                 legal = 1'b0;
        endcase
    end

    // State register and datapath captures.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= S_FETCH;
            op_q     <= 3'd0;
            tgt_q    <= 4'd0;
            zl_q     <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_ld) begin
                op_q  <= instr[7:5];
                tgt_q <= instr[3:0];
            end
            if (ld_zl) begin
                zl_q <= flag_z;
            end
            if (set_halt) begin
                halted_q <= 1'b1;
            end
            if (set_fault) begin
                fault_q <= 1'b1;
            end
        end
    end

`ifdef CALL_STACK_EN
    // Stack pointer is reset; entry contents need no reset since they are
    // only read below the pointer.
    always_ff @(posedge ck) begin
        if (rst) begin
            sp_q <= 3'd0;
        end else if (push) begin
            sp_q <= sp_q + 3'd1;
        end else if (pop) begin
            sp_q <= sp_q - 3'd1;
        end
    end

    always_ff @(posedge ck) begin
        if (!rst && push) begin
            stk_q[sp_q[1:0]] <= pc_in + 4'd1;
        end
    end
`endif

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        pc_opc    = PC_HOLD;
        pc_x      = 1'b0;
        pc_dir    = 4'd0;
        ir_ld     = 1'b0;
        alu_en    = 1'b0;
        reg_we    = 1'b0;
        mem_rd    = 1'b0;
        ld_zl     = 1'b0;
        set_halt  = 1'b0;
        set_fault = 1'b0;
`ifdef CALL_STACK_EN
        push      = 1'b0;
        pop       = 1'b0;
`endif

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_ld   = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                ld_zl = 1'b1;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    set_fault = 1'b1;
                    set_halt  = 1'b1;
                    state_d   = S_STOP;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_ALU: begin
                        pc_opc = PC_UPD;
                        alu_en = 1'b1;
                        reg_we = 1'b1;
                    end
                    OP_LOAD: begin
                        // PC update is deferred to the cycle the data arrives.
                        mem_rd  = 1'b1;
                        state_d = S_MEMW;
                    end
                    OP_JMP: begin
                        pc_opc = PC_UPD;
                        pc_x   = 1'b1;
                        pc_dir = tgt_q;
                    end
                    OP_BRZ: begin
                        pc_opc = PC_UPD;
                        pc_x   = zl_q;
                        pc_dir = tgt_q;
                    end
                    OP_HALT: begin
                        set_halt = 1'b1;
                        state_d  = S_STOP;
                    end
`ifdef CALL_STACK_EN
                    OP_CALL: begin
                        if (sp_q == 3'd4) begin
                            set_fault = 1'b1;
                            set_halt  = 1'b1;
                            state_d   = S_STOP;
                        end else begin
                            push   = 1'b1;
                            pc_opc = PC_UPD;
                            pc_x   = 1'b1;
                            pc_dir = tgt_q;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == 3'd0) begin
                            set_fault = 1'b1;
                            set_halt  = 1'b1;
                            state_d   = S_STOP;
                        end else begin
                            pop    = 1'b1;
                            pc_opc = PC_UPD;
                            pc_x   = 1'b1;
                            pc_dir = stk_q[top_idx];
                        end
                    end
`endif
                    default: begin
                        // Unreachable: DECODE already filtered illegal opcodes.
                        set_fault = 1'b1;
                        set_halt  = 1'b1;
                        state_d   = S_STOP;
                    end
                endcase
            end

            S_MEMW: begin
                if (mem_ready) begin
                    reg_we  = 1'b1;
                    pc_opc  = PC_UPD;
                    state_d = S_FETCH;
                end
            end

            S_STOP: begin
                state_d = S_STOP;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // While rst is held the state is already FETCH, but ir_ld would still
        // follow mem_ready; keep every command quiet for the whole reset.
        if (rst) begin
            pc_opc    = PC_HOLD;
            pc_x      = 1'b0;
            pc_dir    = 4'd0;
            ir_ld     = 1'b0;
            alu_en    = 1'b0;
            reg_we    = 1'b0;
            mem_rd    = 1'b0;
            ld_zl     = 1'b0;
            set_halt  = 1'b0;
            set_fault = 1'b0;
`ifdef CALL_STACK_EN
            push      = 1'b0;
            pop       = 1'b0;
`endif
        end
    end

    assign halted = halted_q;
    assign fault  = fault_q;

endmodule

// File: doc/secuenciador.md
SECUENCIADOR -- requirements
Module: secuenciador

Interface
REQ-001 SHALL have ports ck, rst, then the ports below; one clock ck, reset rst synchronous active-high.
REQ-002 ck  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 instr  in  8  fetched word: [7:5] opcode, [3:0] target/operand, [4] unused.
REQ-005 mem_ready  in  1  instruction/data memory word valid this cycle.
REQ-006 flag_z  in  1  ALU zero flag, sampled in DECODE.
REQ-007 pc_in  in  4  current program-counter value, used only by the return stack.
REQ-008 pc_opc  out  3  command to the program counter: 3'b100 = update, 3'b111 = hold.
REQ-009 pc_x  out  1  with pc_opc=100: 1 = load pc_dir, 0 = increment.
REQ-010 pc_dir  out  4  jump target.
REQ-011 ir_ld  out  1  instruction-register load strobe.
REQ-012 alu_en, reg_we  out  1 each  ALU enable / register-file write strobe.
REQ-013 mem_rd  out  1  data read request (LOAD).
REQ-014 halted, fault  out  1 each  sticky stop indicators.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, EXEC, MEMW, STOP.
REQ-016 FETCH: pc_opc=111; on mem_ready=1, ir_ld=1 that cycle, latch instr, go DECODE; else stay.
REQ-017 DECODE: pc_opc=111; latch flag_z into zl; go EXEC (STOP if opcode illegal).
REQ-018 EXEC SHALL last exactly one cycle and assert pc_opc=100 exactly once per instruction.
REQ-019 Opcode 000 ALU: alu_en=1, reg_we=1, pc_x=0; next FETCH.
REQ-020 Opcode 001 LOAD: mem_rd=1, go MEMW with pc_opc=111; in MEMW on mem_ready: reg_we=1, pc_opc=100, pc_x=0, next FETCH.
REQ-021 Opcode 010 JMP: pc_x=1, pc_dir=instr[3:0]; next FETCH.
REQ-022 Opcode 011 BRZ: pc_x=zl, pc_dir=instr[3:0]; next FETCH.
REQ-023 Opcode 110 HALT: pc_opc=111, halted=1, go STOP.
REQ-024 STOP: all strobes 0, pc_opc=111; exit only by rst.
REQ-025 Outside the cycles listed, pc_opc SHALL be 111 and all strobes 0.
REQ-026 Instruction cost: 3 cycles (ALU/JMP/BRZ) plus mem_ready wait cycles; LOAD 4 minimum.

Reset
REQ-027 rst=1 at any edge SHALL force FETCH, pc_opc=111, pc_x=0, pc_dir=0, all strobes 0, halted=0, fault=0, zl=0, stack pointer 0; overrides in-flight LOAD.

Configuration
REQ-028 Macro CALL_STACK_EN SHALL include a 4-entry return stack.
REQ-029 With CALL_STACK_EN: opcode 101 CALL pushes pc_in+1 (mod 16) and jumps to instr[3:0]; opcode 111 RET pops, pc_x=1, pc_dir=popped value.
REQ-030 With CALL_STACK_EN: CALL at depth 4 or RET at depth 0 SHALL set fault=1, halted=1, go STOP without PC update.
REQ-031 Without CALL_STACK_EN: opcodes 101 and 111 SHALL be illegal: fault=1, halted=1, STOP from DECODE.

Verification
REQ-032 instr=8'h00, mem_ready=1 -> ir_ld at cycle 1, alu_en/reg_we/pc_opc=100,pc_x=0 at cycle 3, ir_ld again at cycle 4.
REQ-033 instr=8'h47 (JMP 7) -> EXEC: pc_opc=100, pc_x=1, pc_dir=7.
REQ-034 BRZ 8'h65 with flag_z=0 in DECODE -> pc_x=0; with flag_z=1 -> pc_x=1, pc_dir=5.
REQ-035 LOAD with mem_ready low 3 cycles in MEMW -> pc_opc=111 throughout, reg_we and pc_opc=100 in the cycle mem_ready rises.
REQ-036 HALT 8'hC0 -> halted=1, pc_opc=111 for 20 cycles; rst pulse -> FETCH, halted=0.
REQ-037 CALL x5 with CALL_STACK_EN -> 5th raises fault; without the macro opcode 101 -> fault after DECODE.
